alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client arbiter/sequencer in front of a single shared 32-bit ALU.
//
// Each client issues an operation over a valid/ready request handshake. One
// client at a time owns the ALU. Its operands and op code are registered and
// drive the ALU. The combinational result is captured one cycle later and
// returned to the owner over a per-client response handshake. Completed
// operations are counted.
//
// Optional build macro:
//   ALU_ARB_FIXED_PRIORITY_EN  client 0 always wins ties (default: round-robin)
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   req_valid/req_ready[1:0] per-client request handshake (bit i = client i)
//   req_a*/req_b*/req_op*    per-client operands and ALUControl code
//   rsp_valid/rsp_ready[1:0] per-client response handshake
//   rsp_result, rsp_zero     captured ALU result and zero flag (shared)
//   alu_a, alu_b, alu_ctrl   registered operands/control to the ALU
//   alu_result, alu_zero     combinational ALU outputs
//   op_count                 completed operations, wraps at 16 bits
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [2:0]  req_op0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [2:0]  req_op1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [2:0]  op_ctrl_q, op_ctrl_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic [15:0] op_count_q, op_count_d;
  logic        grant;

  // Grant selection: a lone requester wins; on a tie the policy decides.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      2'b11:   grant = 1'b0;
`else
      2'b11:   grant = ~last_grant_q;
`endif
      default: grant = 1'b0;
    endcase
  end

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  // last_grant is still tracked in this build but does not steer the grant.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // Ready is gated by reset so nothing is seen as accepted in a reset cycle.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && !reset && (req_valid != 2'b00)) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_ctrl_d    = op_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (req_ready != 2'b00) begin
          owner_d   = grant;
          op_a_d    = grant ? req_a1 : req_a0;
          op_b_d    = grant ? req_b1 : req_b0;
          op_ctrl_d = grant ? req_op1 : req_op0;
          state_d   = StExec;
        end
      end
      StExec: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        state_d      = StResp;
      end
      StResp: begin
        // Only the owner's rsp_ready completes the response.
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          op_count_d   = op_count_q + 16'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_ctrl_q    <= 3'd0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_ctrl_q    <= op_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_ctrl   = op_ctrl_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic, with a
// scoreboard queue filled on request acceptance and drained by a response monitor.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [2:0]  req_op0 = '0, req_op1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [15:0] op_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op0   (req_op0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; codes 110/111 get arbitrary but deterministic results.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a ^ b;
      3'b100:  r = $unsigned($signed(a) >>> b[4:0]);
      3'b101:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110:  r = a | b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic        c;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t        exp_q[$];
  logic        gnt_log[$];
  bit          busy = 1'b0;
  bit          preload = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        m_last = 1'b1;
  logic [15:0] m_count = 16'd0;
  bit          post_reset = 1'b0;

  initial begin
    logic w;
    exp_t e;
    forever begin
      @(negedge clk);
      #4;  // one time unit before the rising edge
      cyc++;
      if (preload) m_count = 16'hFFFF;
      if (reset) begin
        chk("req_ready_in_reset", {30'd0, req_ready}, 32'd0);
        exp_q.delete();
        busy       = 1'b0;
        m_last     = 1'b1;
        m_count    = 16'd0;
        post_reset = 1'b1;
      end else begin
        if (post_reset) begin
          chk("rsp_valid_after_reset", {30'd0, rsp_valid}, 32'd0);
          chk("alu_a_after_reset", alu_a, 32'd0);
          chk("alu_b_after_reset", alu_b, 32'd0);
          chk("alu_ctrl_after_reset", {29'd0, alu_ctrl}, 32'd0);
          post_reset = 1'b0;
        end
        chk("op_count", {16'd0, op_count}, {16'd0, m_count});
        if (busy) begin
          chk("req_ready_busy", {30'd0, req_ready}, 32'd0);
          if (cyc - acc_cyc == 1) begin
            chk("rsp_valid_exec", {30'd0, rsp_valid}, 32'd0);
          end else begin
            e = exp_q[0];
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh(e.c)});
            if (rsp_valid != 2'b00) begin
              chk("rsp_result", rsp_result, e.r);
              chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
              if (rsp_ready[e.c]) begin
                m_last = e.c;
                m_count++;
                busy = 1'b0;
                void'(exp_q.pop_front());
              end
            end
          end
        end else begin
          chk("rsp_valid_idle", {30'd0, rsp_valid}, 32'd0);
          if (req_valid != 2'b00) begin
            if (req_valid == 2'b01) w = 1'b0;
            else if (req_valid == 2'b10) w = 1'b1;
            else w = Fixed ? 1'b0 : ~m_last;
            chk("req_ready_grant", {30'd0, req_ready}, {30'd0, oh(w)});
            if ((req_ready & req_valid) != 2'b00) begin
              e.c = w;
              e.r = w ? alu_fn(req_a1, req_b1, req_op1) : alu_fn(req_a0, req_b0, req_op0);
              e.z = (e.r == 32'd0);
              exp_q.push_back(e);
              gnt_log.push_back(w);
              busy    = 1'b1;
              acc_cyc = cyc;
            end
          end else begin
            chk("req_ready_none", {30'd0, req_ready}, 32'd0);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic c, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    if (c) begin
      req_a1 = a; req_b1 = b; req_op1 = op;
    end else begin
      req_a0 = a; req_b0 = b; req_op0 = op;
    end
  endtask

  task automatic send(input logic c, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op);
    bit done = 1'b0;
    @(negedge clk);
    drive(c, a, b, op);
    req_valid[c] = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #4;
      if (req_ready[c]) done = 1'b1;
      @(negedge clk);
    end
    req_valid[c] = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: client %0d not accepted, required accept in 50 cycles", c);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: still busy, required idle within 60 cycles");
    end
  endtask

  task automatic run_random(input int n);
    logic [1:0]  hs = 2'b00;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (!req_valid[c] || hs[c]) begin
          if ($urandom_range(0, 99) < 60) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(c[0], a, b, 3'($urandom_range(0, 7)));
            req_valid[c] = 1'b1;
          end else begin
            req_valid[c] = 1'b0;
          end
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      #4;
      hs = req_valid & req_ready;
    end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle();
  endtask

  initial begin
    logic exp_order[4];
    bit   got;

    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_op_count", {16'd0, op_count}, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);

    // Client 0 add, client 1 sub to zero, client 1 slt
    send(1'b0, 32'd5, 32'd3, 3'b000);
    wait_idle();
    send(1'b1, 32'd7, 32'd7, 3'b001);
    wait_idle();
    send(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b101);
    wait_idle();
    @(negedge clk);
    chk("count_after_three", {16'd0, op_count}, 32'd3);

    // Both clients valid continuously for four ops
    gnt_log.delete();
    @(negedge clk);
    drive(1'b0, 32'd1, 32'd2, 3'b000);
    drive(1'b1, 32'd10, 32'd3, 3'b001);
    req_valid = 2'b11;
    for (int k = 0; k < 40 && gnt_log.size() < 4; k++) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle();
    for (int i = 0; i < 4; i++) exp_order[i] = Fixed ? 1'b0 : i[0];
    chk("tie_grant_count", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk($sformatf("tie_grant_%0d", i), {31'd0, gnt_log[i]}, {31'd0, exp_order[i]});

    // Back-pressure with the non-owner's rsp_ready high
    rsp_ready = 2'b10;
    send(1'b0, 32'h8000_0000, 32'd4, 3'b100);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) got = 1'b1;
    end
    chk("bp_rsp_seen", {31'd0, got}, 32'd1);
    repeat (5) @(negedge clk);
    chk("bp_rsp_held", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b11;
    wait_idle();

    // Reset during EXEC (send returns in the cycle after accept)
    send(1'b1, 32'd9, 32'd9, 3'b011);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_exec_count", {16'd0, op_count}, 32'd0);

    // Reset during RESP
    rsp_ready = 2'b00;
    send(1'b0, 32'd2, 32'd1, 3'b010);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("rst_resp_rsp_valid", {30'd0, rsp_valid}, 32'd0);

    // Randomized traffic
    run_random(400);

    // Counter wrap: preload 0xFFFF, then one completion
    @(negedge clk);
    preload = 1'b1;
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    preload = 1'b0;
    send(1'b0, 32'd1, 32'd1, 3'b000);
    wait_idle();
    @(negedge clk);
    chk("op_count_wrap", {16'd0, op_count}, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
